text_cursor_writer: RTL
=======================

// Module: text_cursor_writer
// PURPOSE
//  Terminal-style writer between the UART byte decoder and the VGA text-buffer RAM write port.
//  Takes received bytes over the decoder's ready/release handshake and tracks a cursor on a COLS x ROWS grid.
//  Printable bytes are written into the RAM. CR, LF, BS and FF are interpreted.
//  Rows are cleared on entry, and the cursor wraps from the bottom row to the top.
// PARAMETERS
//  COLS        80     characters per row
//  ROWS        30     rows on screen
//  ADDR_WIDTH  12     RAM address width; COLS*ROWS <= 2**ADDR_WIDTH is required (2400 <= 4096)
//  BLANK_CHAR  8'h20  fill byte for clears and backspace
// PORTS
//  i_Clk         in   1           system clock; only clock
//  i_Reset       in   1           synchronous, active-high reset
//  i_Byte        in   8           received byte; valid while i_Byte_Ready=1
//  i_Byte_Ready  in   1           decoder holds a byte (level, held until released)
//  o_Release     out  1           one-cycle pulse: byte consumed
//  o_RAM_Addr    out  ADDR_WIDTH  write address = row*COLS + col
//  o_RAM_Data    out  8           write data
//  o_RAM_WE      out  1           write enable; one RAM write per cycle it is high
//  o_Cursor_Col  out  7           current column, 0..COLS-1
//  o_Cursor_Row  out  5           current row, 0..ROWS-1
//  o_Busy        out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0; cursor (0,0); state IDLE.
//   - Mid-operation reset abandons the operation. No release is issued and no RAM contents are cleared.
//   - A byte still held by the decoder is processed after reset.
//  FSM: IDLE -> DECODE -> {WRITE | CLEAR} -> RELEASE -> WAIT_LOW -> IDLE.
//   - IDLE: on i_Byte_Ready=1, latch i_Byte and go to DECODE.
//   - DECODE (1 cycle): classify the latched byte and compute the next cursor.
//   - WRITE (1 cycle): o_RAM_WE=1 with o_RAM_Addr/o_RAM_Data valid.
//   - CLEAR: one blank write per cycle over a start..end address range.
//   - RELEASE (1 cycle): o_Release=1.
//   - WAIT_LOW: stay until i_Byte_Ready=0, so no byte is processed twice.
//  Latency, printable byte: ready seen in cycle N -> WE in N+2 -> o_Release in N+3.
//  Byte classes:
//   - 0x20..0x7E: write at (row,col), then col+1.
//     At col=COLS-1 the cursor goes to col=0, row+1 (ROWS-1 wraps to 0), and the new row is CLEARed.
//   - 0x0D CR: col=0; no write.
//   - 0x0A LF: row+1 with wrap; col unchanged; CLEAR the new row (COLS writes).
//   - 0x08 BS: if col>0, col-1 and WRITE BLANK_CHAR at the new position. At col=0, no-op.
//   - 0x0C FF: CLEAR addresses 0..COLS*ROWS-1, then cursor (0,0).
//   - Any other byte: ignored; still released.
//  Row clear runs over addresses row*COLS .. row*COLS+COLS-1, ascending. After a wrap clear, the cursor is at (newrow,0).
//  Arithmetic: address computed in ADDR_WIDTH bits, unsigned; col/row never leave their ranges.
//  Cursor outputs update in the cycle the operation finishes, at the latest by RELEASE.
//  i_Byte changes while not in IDLE are ignored; the latched copy is used.
// STRUCTURE
//  Package text_term_pkg holds:
//   - CHAR_CR/LF/BS/FF, CHAR_PRINT_LO/HI, BLANK_CHAR default
//   - state encoding localparams
//  One sub-module, text_clear_sequencer: start address plus count in; emits addr/WE one per cycle; done pulse out.
//  Used for row clears and full-screen clears.
//  Cursor registers and FSM stay in text_cursor_writer.
// TESTING
//  1. Reset, send 'A' (0x41) -> WE once at addr 0, data 0x41, in cycle N+2; release at N+3; cursor (0,1).
//  2. Send 80 x 'B' from (0,0) -> writes at 0..79; after the last, 80 blank writes at 80..159; cursor (1,0).
//  3. Cursor (29,5), send LF -> row wraps to 0; blanks written at 0..79; cursor (0,5).
//  4. Cursor (3,10), send BS -> one WE of 0x20 at addr 249; cursor (3,9). Cursor (3,0), BS -> no WE; cursor unchanged; still released.
//  5. Send FF -> 2400 consecutive blank writes at 0..2399, then release; cursor (0,0).
//  6. Hold i_Byte_Ready high across release -> exactly one write until ready drops.
//     Reset asserted mid-FF -> WE low the next cycle, cursor (0,0), no o_Release.

Source files
------------

// File: rtl/text_term_pkg.sv
// Shared types and character constants for the
// UART-to-text-buffer terminal writer.
package text_term_pkg;

  localparam logic [7:0] CHAR_CR        = 8'h0D;
  localparam logic [7:0] CHAR_LF        = 8'h0A;
  localparam logic [7:0] CHAR_BS        = 8'h08;
  localparam logic [7:0] CHAR_FF        = 8'h0C;
  localparam logic [7:0] CHAR_PRINT_LO  = 8'h20;
  localparam logic [7:0] CHAR_PRINT_HI  = 8'h7E;
  localparam logic [7:0] BLANK_CHAR_DEF = 8'h20;

  localparam int COL_W = 7;
  localparam int ROW_W = 5;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_WRITE    = 3'd2;
  localparam logic [2:0] S_CLEAR    = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;
  localparam logic [2:0] S_WAIT_LOW = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_DECODE   = S_DECODE,
    ST_WRITE    = S_WRITE,
    ST_CLEAR    = S_CLEAR,
    ST_RELEASE  = S_RELEASE,
    ST_WAIT_LOW = S_WAIT_LOW
  } state_t;

  typedef enum logic [2:0] {
    CLS_PRINT,
    CLS_CR,
    CLS_LF,
    CLS_BS,
    CLS_FF,
    CLS_OTHER
  } char_class_t;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
  } cursor_t;

  function automatic char_class_t classify(
    input logic [7:0] b
  );
    char_class_t c;
    unique case (1'b1)
      (b >= CHAR_PRINT_LO) &&
      (b <= CHAR_PRINT_HI): c = CLS_PRINT;
      (b == CHAR_CR):       c = CLS_CR;
      (b == CHAR_LF):       c = CLS_LF;
      (b == CHAR_BS):       c = CLS_BS;
      (b == CHAR_FF):       c = CLS_FF;
      default:              c = CLS_OTHER;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/text_clear_sequencer.sv
// Walks an ascending address range, one blank write
// per cycle, and flags the last write with done.
module text_clear_sequencer #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  we,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] ONE =
    (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(1);

  logic                  active;
  logic [ADDR_WIDTH:0]   left;
  logic [ADDR_WIDTH-1:0] cur;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      active <= 1'b0;
      left   <= '0;
      cur    <= '0;
    end else if (start) begin
      active <= (count != '0);
      left   <= count;
      cur    <= start_addr;
    end else if (active) begin
      cur  <= cur + STEP;
      left <= left - ONE;
      if (left == ONE) active <= 1'b0;
    end
  end

  assign addr = cur;
  assign we   = active;
  assign done = active && (left == ONE);

endmodule

// File: rtl/text_cursor_writer.sv
// Terminal-style byte writer: tracks a cursor and
// drives the text-buffer RAM write port.
module text_cursor_writer
  import text_term_pkg::*;
#(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter int          ADDR_WIDTH = 12,
  parameter logic [7:0]  BLANK_CHAR = BLANK_CHAR_DEF
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic [7:0]            i_Byte,
  input  logic                  i_Byte_Ready,
  output logic                  o_Release,
  output logic [ADDR_WIDTH-1:0] o_RAM_Addr,
  output logic [7:0]            o_RAM_Data,
  output logic                  o_RAM_WE,
  output logic [6:0]            o_Cursor_Col,
  output logic [4:0]            o_Cursor_Row,
  output logic                  o_Busy
);

  localparam logic [COL_W-1:0] LAST_COL =
    COL_W'(COLS-1);
  localparam logic [ROW_W-1:0] LAST_ROW =
    ROW_W'(ROWS-1);
  localparam logic [ADDR_WIDTH:0] ROW_CNT =
    (ADDR_WIDTH+1)'(COLS);
  localparam logic [ADDR_WIDTH:0] SCR_CNT =
    (ADDR_WIDTH+1)'(COLS*ROWS);

  function automatic logic [ADDR_WIDTH-1:0] addr_of(
    input logic [ROW_W-1:0] r,
    input logic [COL_W-1:0] c
  );
    return ADDR_WIDTH'(r) * ADDR_WIDTH'(COLS)
         + ADDR_WIDTH'(c);
  endfunction

  state_t state, state_d;

  logic [7:0]            byte_q;
  cursor_t               cur, nxt_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [7:0]            wr_data_q;
  logic                  clr_after_q;
  logic [ADDR_WIDTH-1:0] clr_start_q;
  logic [ADDR_WIDTH:0]   clr_count_q;

  cursor_t               dec_cur;
  logic [ADDR_WIDTH-1:0] dec_wr_addr;
  logic [7:0]            dec_wr_data;
  logic                  dec_clr_after;
  logic [ADDR_WIDTH-1:0] dec_clr_start;
  logic [ADDR_WIDTH:0]   dec_clr_count;
  state_t                dec_next;
  logic [ROW_W-1:0]      row_inc;

  logic                  seq_start;
  logic [ADDR_WIDTH-1:0] seq_start_addr;
  logic [ADDR_WIDTH:0]   seq_count;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic                  seq_we;
  logic                  seq_done;

  assign row_inc = (cur.row == LAST_ROW) ?
    '0 : cur.row + ROW_W'(1);

  always_comb begin
    dec_cur       = cur;
    dec_wr_addr   = addr_of(cur.row, cur.col);
    dec_wr_data   = byte_q;
    dec_clr_after = 1'b0;
    dec_clr_start = addr_of(row_inc, '0);
    dec_clr_count = ROW_CNT;
    dec_next      = ST_RELEASE;
    unique case (classify(byte_q))
      CLS_PRINT: begin
        dec_next = ST_WRITE;
        if (cur.col == LAST_COL) begin
          dec_cur.col   = '0;
          dec_cur.row   = row_inc;
          dec_clr_after = 1'b1;
        end else begin
          dec_cur.col = cur.col + COL_W'(1);
        end
      end
      CLS_CR: dec_cur.col = '0;
      CLS_LF: begin
        dec_cur.row = row_inc;
        dec_next    = ST_CLEAR;
      end
      CLS_BS: begin
        if (cur.col != '0) begin
          dec_cur.col = cur.col - COL_W'(1);
          dec_wr_addr =
            addr_of(cur.row, cur.col - COL_W'(1));
          dec_wr_data = BLANK_CHAR;
          dec_next    = ST_WRITE;
        end
      end
      CLS_FF: begin
        dec_cur       = '0;
        dec_clr_start = '0;
        dec_clr_count = SCR_CNT;
        dec_next      = ST_CLEAR;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state;
    seq_start = 1'b0;
    unique case (state)
      ST_IDLE:
        if (i_Byte_Ready) state_d = ST_DECODE;
      ST_DECODE: begin
        state_d   = dec_next;
        seq_start = (dec_next == ST_CLEAR);
      end
      ST_WRITE: begin
        if (clr_after_q) begin
          state_d   = ST_CLEAR;
          seq_start = 1'b1;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      ST_CLEAR:
        if (seq_done) state_d = ST_RELEASE;
      ST_RELEASE:
        state_d = ST_WAIT_LOW;
      ST_WAIT_LOW:
        if (!i_Byte_Ready) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // A clear launched straight from DECODE has not been registered yet
  assign seq_start_addr = (state == ST_DECODE) ?
    dec_clr_start : clr_start_q;
  assign seq_count = (state == ST_DECODE) ?
    dec_clr_count : clr_count_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      byte_q      <= '0;
      cur         <= '0;
      nxt_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      clr_after_q <= 1'b0;
      clr_start_q <= '0;
      clr_count_q <= '0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && i_Byte_Ready)
        byte_q <= i_Byte;
      if (state == ST_DECODE) begin
        nxt_q       <= dec_cur;
        wr_addr_q   <= dec_wr_addr;
        wr_data_q   <= dec_wr_data;
        clr_after_q <= dec_clr_after;
        clr_start_q <= dec_clr_start;
        clr_count_q <= dec_clr_count;
      end
      if (state_d == ST_RELEASE &&
          state != ST_RELEASE)
        cur <= (state == ST_DECODE) ?
          dec_cur : nxt_q;
    end
  end

  text_clear_sequencer #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .start      (seq_start),
    .start_addr (seq_start_addr),
    .count      (seq_count),
    .addr       (seq_addr),
    .we         (seq_we),
    .done       (seq_done)
  );

  always_comb begin
    o_RAM_WE   = 1'b0;
    o_RAM_Addr = '0;
    o_RAM_Data = '0;
    if (state == ST_WRITE) begin
      o_RAM_WE   = 1'b1;
      o_RAM_Addr = wr_addr_q;
      o_RAM_Data = wr_data_q;
    end else if (state == ST_CLEAR) begin
      o_RAM_WE   = seq_we;
      o_RAM_Addr = seq_addr;
      o_RAM_Data = BLANK_CHAR;
    end
  end

  assign o_Release    = (state == ST_RELEASE);
  assign o_Busy       = (state != ST_IDLE);
  assign o_Cursor_Col = cur.col;
  assign o_Cursor_Row = cur.row;

endmodule
